rpc_call_arbiter: RTL and testbench

Shares one Kiwi RPC server instance between `N_CLIENTS` client threads. Each client and the server use a four-phase req/ack handshake. The arbiter:
- picks one pending client by round-robin,
- forwards its argument word to the server,
- captures the server's result and returns it to that client,
- then closes both handshakes before granting again.

It sits between the client threads of the RPC demo system and the single server, inside the simulation/synthesis top alongside the clients.

---
 rtl/rpc_call_arbiter_pkg.sv | 17 +
 rtl/rpc_call_arbiter_rr_pick.sv | 30 +++
 rtl/rpc_call_arbiter.sv | 140 ++++++++++++++
 tb/tb_rpc_call_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rpc_call_arbiter_pkg.sv
// Shared types for rpc_call_arbiter: FSM state encoding and round-robin pointer width.
package rpc_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALL    = 3'd1,
    SRV_RTZ = 3'd2,
    REPLY   = 3'd3,
    CLI_RTZ = 3'd4
  } rpc_arb_state_t;

  // Width of rr_ptr / grant index; at least one bit even for a lone client.
  function automatic int rr_ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rpc_call_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = PW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/rpc_call_arbiter.sv
// Round-robin arbiter sharing one req/ack RPC server among N_CLIENTS clients.
// Define RPC_ARB_TIMEOUT_EN to add a server-ack watchdog that aborts stuck calls.
module rpc_call_arbiter
  import rpc_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int ARG_W     = 32,
  parameter int RES_W     = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CLIENTS-1:0]         cli_req,
  input  logic [N_CLIENTS*ARG_W-1:0]   cli_args,
  output logic [N_CLIENTS-1:0]         cli_ack,
  output logic [N_CLIENTS-1:0]         cli_err,
  output logic [RES_W-1:0]             cli_result,
  output logic                         srv_req,
  output logic [ARG_W-1:0]             srv_args,
  input  logic                         srv_ack,
  input  logic [RES_W-1:0]             srv_result,
  output logic                         busy
);

  localparam int PW = rr_ptr_w(N_CLIENTS);

  rpc_arb_state_t                       state;
  logic [PW-1:0]                        rr_ptr, gidx, pick_idx, nxt_ptr;
  logic [N_CLIENTS-1:0]                 gnt_q, pick_gnt;
  logic                                 pick_any;
  logic [RES_W-1:0]                     res_q;
  logic [N_CLIENTS-1:0][ARG_W-1:0]      args_v;

  assign args_v  = cli_args;
  assign nxt_ptr = (gidx == PW'(N_CLIENTS - 1)) ? '0 : gidx + 1'b1;

  rr_pick #(.N(N_CLIENTS), .PW(PW)) u_pick (
    .req (cli_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef RPC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          abort_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign cli_err = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gidx       <= '0;
      gnt_q      <= '0;
      res_q      <= '0;
      srv_req    <= 1'b0;
      srv_args   <= '0;
      cli_ack    <= '0;
      cli_result <= '0;
      busy       <= 1'b0;
`ifdef RPC_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      abort_q    <= 1'b0;
      cli_err    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Requests are only sampled here; anything raised mid-call waits.
          if (pick_any) begin
            gidx     <= pick_idx;
            gnt_q    <= pick_gnt;
            srv_args <= args_v[pick_idx];
            srv_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= CALL;
`ifdef RPC_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
            abort_q  <= 1'b0;
`endif
          end
        end
        CALL: begin
          if (srv_ack) begin
            res_q   <= srv_result;
            srv_req <= 1'b0;
            state   <= SRV_RTZ;
          end
`ifdef RPC_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            res_q   <= '0;
            abort_q <= 1'b1;
            srv_req <= 1'b0;
            state   <= SRV_RTZ;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        SRV_RTZ: begin
          if (!srv_ack) begin
            cli_ack    <= gnt_q;
            cli_result <= res_q;
`ifdef RPC_ARB_TIMEOUT_EN
            cli_err    <= abort_q ? gnt_q : '0;
`endif
            state      <= REPLY;
          end
        end
        REPLY: begin
          if ((cli_req & gnt_q) == '0) begin
            cli_ack <= '0;
`ifdef RPC_ARB_TIMEOUT_EN
            cli_err <= '0;
`endif
            rr_ptr  <= nxt_ptr;
            state   <= CLI_RTZ;
          end
        end
        CLI_RTZ: begin
          // Dead cycle so a re-raised req from the same client counts as a new call.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          srv_req <= 1'b0;
          cli_ack <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpc_call_arbiter.sv
// Directed table-driven bench for rpc_call_arbiter plus reset/timeout sequences.
module tb_rpc_call_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     cli_req;
  logic [N*W-1:0]   cli_args;
  logic [N-1:0]     cli_ack, cli_err;
  logic [W-1:0]     cli_result;
  logic             srv_req;
  logic [W-1:0]     srv_args;
  logic             srv_ack;
  logic [W-1:0]     srv_result;
  logic             busy;

  logic [W-1:0]     args [N];

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [31:0] res;
    int         dly;
    int         hold;
    int         exp_g;
  } vec_t;

  vec_t vt [10];

  always #5 clk = ~clk;

  rpc_call_arbiter #(.N_CLIENTS(N), .ARG_W(W), .RES_W(W), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cli_req    (cli_req),
    .cli_args   (cli_args),
    .cli_ack    (cli_ack),
    .cli_err    (cli_err),
    .cli_result (cli_result),
    .srv_req    (srv_req),
    .srv_args   (srv_args),
    .srv_ack    (srv_ack),
    .srv_result (srv_result),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts and ends on a negedge with the arbiter in IDLE.
  task automatic do_call(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.exp_g;
    if (v.rst) pulse_reset();
    cli_req = v.req;
    @(negedge clk);
    chk("srv_req_rise", {31'd0, srv_req}, 32'd1);
    chk("srv_args", srv_args, args[v.exp_g]);
    chk("busy_call", {31'd0, busy}, 32'd1);
    repeat (v.dly) @(negedge clk);
    srv_ack    = 1'b1;
    srv_result = v.res;
    @(negedge clk);
    chk("srv_req_fall", {31'd0, srv_req}, 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      chk("ack_while_srv_ack", {28'd0, cli_ack}, 32'd0);
      @(negedge clk);
    end
    srv_ack    = 1'b0;
    srv_result = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("cli_ack", {28'd0, cli_ack}, {28'd0, oh});
    chk("cli_result", cli_result, v.res);
    chk("cli_err", {28'd0, cli_err}, 32'd0);
    cli_req[v.exp_g] = 1'b0;
    @(negedge clk);
    chk("ack_drop", {28'd0, cli_ack}, 32'd0);
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    args[0] = 32'h0000_00A0;
    args[1] = 32'h0000_00B1;
    args[2] = 32'h0000_0011;
    args[3] = 32'h0000_00D3;
    cli_args   = {args[3], args[2], args[1], args[0]};
    reset      = 1'b1;
    cli_req    = '0;
    srv_ack    = 1'b0;
    srv_result = '0;

    //          rst   req      res           dly hold g
    vt[0] = '{1'b1, 4'b0100, 32'h0000_0022, 3, 0, 2};
    vt[1] = '{1'b1, 4'b1111, 32'h0000_0100, 0, 0, 0};
    vt[2] = '{1'b0, 4'b1111, 32'h0000_0101, 1, 0, 1};
    vt[3] = '{1'b0, 4'b1111, 32'h0000_0102, 0, 0, 2};
    vt[4] = '{1'b0, 4'b1111, 32'h0000_0103, 2, 0, 3};
    vt[5] = '{1'b0, 4'b1111, 32'h0000_0104, 0, 0, 0};
    vt[6] = '{1'b0, 4'b0100, 32'h0000_0200, 0, 0, 2};
    vt[7] = '{1'b0, 4'b1010, 32'h0000_0203, 1, 0, 3};
    vt[8] = '{1'b0, 4'b1010, 32'h0000_0201, 0, 0, 1};
    vt[9] = '{1'b0, 4'b0001, 32'hCAFE_0300, 1, 3, 0};

    @(negedge clk);
    chk("rst_srv_req", {31'd0, srv_req}, 32'd0);
    chk("rst_srv_args", srv_args, 32'd0);
    chk("rst_cli_ack", {28'd0, cli_ack}, 32'd0);
    chk("rst_cli_err", {28'd0, cli_err}, 32'd0);
    chk("rst_cli_result", cli_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 10; r++) do_call(vt[r]);

    // Reset in the second cycle of CALL abandons the call asynchronously.
    pulse_reset();
    cli_req = 4'b0010;
    @(negedge clk);
    chk("mid_srv_req_up", {31'd0, srv_req}, 32'd1);
    chk("mid_srv_args", srv_args, args[1]);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_srv_req", {31'd0, srv_req}, 32'd0);
    chk("mid_rst_cli_ack", {28'd0, cli_ack}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    cli_req = '0;
    @(negedge clk);
    do_call('{1'b0, 4'b1111, 32'h0000_0400, 0, 0, 0});
    cli_req = '0;

`ifdef RPC_ARB_TIMEOUT_EN
    // Server never acks: watchdog drops srv_req 16 cycles after it rose.
    pulse_reset();
    cli_req = 4'b0001;
    @(negedge clk);
    chk("tmo_srv_req_up", {31'd0, srv_req}, 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("tmo_srv_req_held", {31'd0, srv_req}, 32'd1);
    end
    @(negedge clk);
    chk("tmo_srv_req_fall", {31'd0, srv_req}, 32'd0);
    @(negedge clk);
    chk("tmo_cli_ack", {28'd0, cli_ack}, 32'd1);
    chk("tmo_cli_err", {28'd0, cli_err}, 32'd1);
    chk("tmo_cli_result", cli_result, 32'd0);
    cli_req = '0;
    @(negedge clk);
    chk("tmo_err_drop", {28'd0, cli_err}, 32'd0);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
